// File: rtl/iic_eeprom_slave.sv
// I2C responder modelling a 24C02-style 256x8 EEPROM. SCL/SDA are oversampled on CLK,
// so every bus event is reacted to a few CLK cycles after the filtered edge.
module iic_eeprom_slave #(
    parameter logic [6:0] DEV_ADDR   = 7'b1010000,
    parameter int         PAGE_SIZE  = 8,
    parameter int         GLITCH_CYC = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       SCL,
    inout  wire        SDA,
    output logic       Busy,
    output logic       Wr_Pulse,
    output logic [7:0] Wr_Addr,
    output logic [7:0] Wr_Data
);
    localparam logic [7:0] PAGE_MASK = 8'(PAGE_SIZE - 1);
    localparam int         CNT_W     = $clog2(GLITCH_CYC + 1);

    typedef enum logic [3:0] {
        IDLE, DEVADDR, DEVACK, WORDADDR, WAACK, WRDATA, WRACK, RDDATA, MACK, IGNORE
    } state_t;

    // Bit 0 carries SCL, bit 1 carries SDA through identical conditioning.
    logic [1:0] pin_raw;
    logic [1:0] lvl;
    logic [1:0] lvl_dly;
    assign pin_raw = {SDA, SCL};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_in
            logic             sync1_reg, sync2_reg, flt_reg, dly_reg;
            logic [CNT_W-1:0] cnt_reg;
            always_ff @(posedge CLK) begin
                if (RST) begin
                    sync1_reg <= 1'b1;
                    sync2_reg <= 1'b1;
                    flt_reg   <= 1'b1;
                    dly_reg   <= 1'b1;
                    cnt_reg   <= '0;
                end else begin
                    sync1_reg <= pin_raw[gi];
                    sync2_reg <= sync1_reg;
                    dly_reg   <= flt_reg;
                    if (sync2_reg == flt_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == CNT_W'(GLITCH_CYC - 1)) begin
                        flt_reg <= sync2_reg;
                        cnt_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            end
            assign lvl[gi]     = flt_reg;
            assign lvl_dly[gi] = dly_reg;
        end
    endgenerate

    logic sda, scl_rise, scl_fall, scl_high, start_det, stop_det;
    assign sda       = lvl[1];
    assign scl_rise  = lvl[0] & ~lvl_dly[0];
    assign scl_fall  = ~lvl[0] & lvl_dly[0];
    assign scl_high  = lvl[0] | lvl_dly[0];
    assign start_det = scl_high & lvl_dly[1] & ~lvl[1];
    assign stop_det  = scl_high & ~lvl_dly[1] & lvl[1];

    state_t     state_reg, state_next;
    logic [2:0] bit_cnt_reg, bit_cnt_next;
    logic [6:0] shift_reg, shift_next;
    logic [6:0] tx_reg, tx_next;
    logic       phase_reg, phase_next;
    logic       rw_reg, rw_next;
    logic       sda_oe_reg, sda_oe_next;
    logic       busy_reg, busy_next;
    logic [7:0] addr_ptr_reg, addr_ptr_next;
    logic       wr_pulse_reg, wr_pulse_next;
    logic [7:0] wr_addr_reg, wr_addr_next;
    logic [7:0] wr_data_reg, wr_data_next;
    logic       mem_we;
    logic [7:0] rx_byte;
    logic [7:0] rd_data_reg;
    logic [7:0] mem [0:255];

    assign rx_byte = {shift_reg, sda};

    always_ff @(posedge CLK) begin
        if (mem_we) mem[addr_ptr_reg] <= rx_byte;
        rd_data_reg <= mem[addr_ptr_reg];
    end

    // Ack states use phase_reg: first SCL fall starts driving 0, second fall ends the bit.
    always_comb begin
        state_next    = state_reg;
        bit_cnt_next  = bit_cnt_reg;
        shift_next    = shift_reg;
        tx_next       = tx_reg;
        phase_next    = phase_reg;
        rw_next       = rw_reg;
        sda_oe_next   = sda_oe_reg;
        busy_next     = busy_reg;
        addr_ptr_next = addr_ptr_reg;
        wr_pulse_next = 1'b0;
        wr_addr_next  = wr_addr_reg;
        wr_data_next  = wr_data_reg;
        mem_we        = 1'b0;
        if (stop_det) begin
            state_next   = IDLE;
            busy_next    = 1'b0;
            sda_oe_next  = 1'b0;
            bit_cnt_next = 3'd0;
            phase_next   = 1'b0;
        end else if (start_det) begin
            state_next   = DEVADDR;
            sda_oe_next  = 1'b0;
            bit_cnt_next = 3'd0;
            phase_next   = 1'b0;
        end else begin
            case (state_reg)
                IDLE, IGNORE: ;
                DEVADDR, WORDADDR, WRDATA: begin
                    if (scl_rise) begin
                        shift_next   = rx_byte[6:0];
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                        phase_next   = 1'b0;
                        if (bit_cnt_reg == 3'd7) begin
                            if (state_reg == DEVADDR) begin
                                if (shift_reg == DEV_ADDR) begin
                                    state_next = DEVACK;
                                    rw_next    = sda;
                                    busy_next  = 1'b1;
                                end else begin
                                    state_next = IGNORE;
                                end
                            end else if (state_reg == WORDADDR) begin
                                state_next    = WAACK;
                                addr_ptr_next = rx_byte;
                            end else begin
                                state_next    = WRACK;
                                mem_we        = 1'b1;
                                wr_pulse_next = 1'b1;
                                wr_addr_next  = addr_ptr_reg;
                                wr_data_next  = rx_byte;
                                addr_ptr_next = (addr_ptr_reg & ~PAGE_MASK) |
                                                ((addr_ptr_reg + 8'd1) & PAGE_MASK);
                            end
                        end
                    end
                end
                DEVACK, WAACK, WRACK: begin
                    if (scl_fall) begin
                        if (!phase_reg) begin
                            sda_oe_next = 1'b1;
                            phase_next  = 1'b1;
                        end else begin
                            phase_next   = 1'b0;
                            bit_cnt_next = 3'd0;
                            if (state_reg == DEVACK && rw_reg) begin
                                state_next  = RDDATA;
                                tx_next     = rd_data_reg[6:0];
                                sda_oe_next = ~rd_data_reg[7];
                            end else begin
                                state_next  = (state_reg == DEVACK) ? WORDADDR : WRDATA;
                                sda_oe_next = 1'b0;
                            end
                        end
                    end
                end
                RDDATA: begin
                    if (scl_fall) begin
                        if (bit_cnt_reg == 3'd7) begin
                            sda_oe_next  = 1'b0;
                            state_next   = MACK;
                            phase_next   = 1'b0;
                            bit_cnt_next = 3'd0;
                        end else begin
                            sda_oe_next  = ~tx_reg[6];
                            tx_next      = {tx_reg[5:0], 1'b0};
                            bit_cnt_next = bit_cnt_reg + 3'd1;
                        end
                    end
                end
                MACK: begin
                    if (scl_rise) begin
                        if (sda) begin
                            state_next = IGNORE;
                        end else begin
                            addr_ptr_next = addr_ptr_reg + 8'd1;
                            phase_next    = 1'b1;
                        end
                    end else if (scl_fall && phase_reg) begin
                        state_next   = RDDATA;
                        phase_next   = 1'b0;
                        bit_cnt_next = 3'd0;
                        tx_next      = rd_data_reg[6:0];
                        sda_oe_next  = ~rd_data_reg[7];
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg    <= IDLE;
            bit_cnt_reg  <= 3'd0;
            shift_reg    <= 7'd0;
            tx_reg       <= 7'd0;
            phase_reg    <= 1'b0;
            rw_reg       <= 1'b0;
            sda_oe_reg   <= 1'b0;
            busy_reg     <= 1'b0;
            addr_ptr_reg <= 8'd0;
            wr_pulse_reg <= 1'b0;
            wr_addr_reg  <= 8'd0;
            wr_data_reg  <= 8'd0;
        end else begin
            state_reg    <= state_next;
            bit_cnt_reg  <= bit_cnt_next;
            shift_reg    <= shift_next;
            tx_reg       <= tx_next;
            phase_reg    <= phase_next;
            rw_reg       <= rw_next;
            sda_oe_reg   <= sda_oe_next;
            busy_reg     <= busy_next;
            addr_ptr_reg <= addr_ptr_next;
            wr_pulse_reg <= wr_pulse_next;
            wr_addr_reg  <= wr_addr_next;
            wr_data_reg  <= wr_data_next;
        end
    end

    assign SDA      = sda_oe_reg ? 1'b0 : 1'bz;
    assign Busy     = busy_reg;
    assign Wr_Pulse = wr_pulse_reg;
    assign Wr_Addr  = wr_addr_reg;
    assign Wr_Data  = wr_data_reg;
endmodule

// File: tb/tb_iic_eeprom_slave.sv
// Bit-banged I2C master driving iic_eeprom_slave against an array/pointer model of a 24C02.
module tb_iic_eeprom_slave;
    localparam int         Q    = 10;
    localparam int         PAGE = 8;
    localparam logic [6:0] DEV  = 7'b1010000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       m_scl = 1'b1;
    logic       m_sda_low = 1'b0;
    wire        sda_bus;
    logic       busy, wr_pulse;
    logic [7:0] wr_addr, wr_data;

    always #5 clk = ~clk;

    pullup (sda_bus);
    assign sda_bus = m_sda_low ? 1'b0 : 1'bz;

    iic_eeprom_slave #(.DEV_ADDR(DEV), .PAGE_SIZE(PAGE), .GLITCH_CYC(2)) dut (
        .CLK(clk), .RST(rst), .SCL(m_scl), .SDA(sda_bus),
        .Busy(busy), .Wr_Pulse(wr_pulse), .Wr_Addr(wr_addr), .Wr_Data(wr_data)
    );

    int          n_vec = 0;
    int          n_err = 0;
    int          txn   = 0;
    logic [7:0]  ref_mem [256];
    bit          ref_known [256];
    int          ref_ptr = 0;
    logic [15:0] exp_wr_q [$];
    logic [15:0] mon_wr_q [$];
    logic [7:0]  wbuf [8];

    always @(negedge clk) if (wr_pulse) mon_wr_q.push_back({wr_addr, wr_data});

    initial begin
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog: cycle budget exhausted, got running want finished");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
        end
    endtask

    task automatic q_wait;
        repeat (Q) @(negedge clk);
    endtask

    task automatic bus_start;
        m_sda_low = 1'b0; q_wait; m_scl = 1'b1; q_wait;
        m_sda_low = 1'b1; q_wait; m_scl = 1'b0; q_wait;
    endtask

    task automatic bus_stop;
        m_sda_low = 1'b1; q_wait; m_scl = 1'b1; q_wait;
        m_sda_low = 1'b0; q_wait;
    endtask

    task automatic send_bit(input bit b);
        m_sda_low = ~b; q_wait; m_scl = 1'b1; q_wait; q_wait; m_scl = 1'b0; q_wait;
    endtask

    task automatic recv_bit(output bit b);
        m_sda_low = 1'b0; q_wait; m_scl = 1'b1; q_wait;
        b = sda_bus; q_wait; m_scl = 1'b0; q_wait;
    endtask

    task automatic send_byte(input logic [7:0] d, output bit ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(ack);
    endtask

    task automatic recv_byte(input bit nack, output logic [7:0] d);
        bit b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        send_bit(nack);
    endtask

    task automatic check_writes;
        check_eq("wr_count", 16'(mon_wr_q.size()), 16'(exp_wr_q.size()));
        while (exp_wr_q.size() > 0 && mon_wr_q.size() > 0)
            check_eq("wr_record", mon_wr_q.pop_front(), exp_wr_q.pop_front());
        exp_wr_q.delete();
        mon_wr_q.delete();
    endtask

    // Write transaction: address byte then n data bytes from wbuf, then STOP.
    task automatic do_write(input logic [6:0] dev, input logic [7:0] addr, input int n);
        bit ack;
        bit hit;
        hit = (dev == DEV);
        bus_start;
        send_byte({dev, 1'b0}, ack);
        check_eq("dev_ack", 16'(ack), 16'(!hit));
        check_eq("busy_after_devack", 16'(busy), 16'(hit));
        send_byte(addr, ack);
        check_eq("addr_ack", 16'(ack), 16'(!hit));
        if (hit) ref_ptr = addr;
        for (int k = 0; k < n; k++) begin
            send_byte(wbuf[k], ack);
            check_eq("data_ack", 16'(ack), 16'(!hit));
            if (hit) begin
                ref_mem[ref_ptr]   = wbuf[k];
                ref_known[ref_ptr] = 1'b1;
                exp_wr_q.push_back({8'(ref_ptr), wbuf[k]});
                ref_ptr = (ref_ptr / PAGE) * PAGE + ((ref_ptr % PAGE) + 1) % PAGE;
            end
        end
        bus_stop;
        q_wait;
        check_eq("busy_after_stop", 16'(busy), 16'h0);
        check_writes;
        txn++;
        $display("txn %0d: write dev=0x%0h addr=0x%0h bytes=%0d", txn, dev, addr, n);
    endtask

    // Read n bytes (ACK all but the last); optionally set the pointer first (random read).
    task automatic do_read(input logic [7:0] addr, input bit set_addr, input int n);
        bit         ack;
        logic [7:0] d;
        if (set_addr) begin
            bus_start;
            send_byte({DEV, 1'b0}, ack);
            check_eq("rd_setup_dev_ack", 16'(ack), 16'h0);
            send_byte(addr, ack);
            check_eq("rd_setup_addr_ack", 16'(ack), 16'h0);
            ref_ptr = addr;
        end
        bus_start;
        send_byte({DEV, 1'b1}, ack);
        check_eq("rd_dev_ack", 16'(ack), 16'h0);
        for (int k = 0; k < n; k++) begin
            recv_byte(k == n - 1, d);
            if (ref_known[ref_ptr]) check_eq("rd_data", 16'(d), 16'(ref_mem[ref_ptr]));
            if (k < n - 1) ref_ptr = (ref_ptr + 1) % 256;
        end
        bus_stop;
        q_wait;
        check_eq("rd_busy_after_stop", 16'(busy), 16'h0);
        check_writes;
        txn++;
        $display("txn %0d: read start=0x%0h bytes=%0d", txn, set_addr ? addr : 8'hxx, n);
    endtask

    initial begin
        bit         ack, b;
        logic [3:0] nib;
        logic [7:0] r0;
        logic [7:0] addr;
        int         n;
        logic [6:0] dev;

        repeat (5) @(negedge clk);
        check_eq("rst_busy", 16'(busy), 16'h0);
        check_eq("rst_wr_pulse", 16'(wr_pulse), 16'h0);
        check_eq("rst_wr_addr", 16'(wr_addr), 16'h0);
        check_eq("rst_wr_data", 16'(wr_data), 16'h0);
        check_eq("rst_sda", 16'(sda_bus), 16'h1);
        rst = 1'b0;
        q_wait;

        wbuf[0] = 8'h12;
        do_write(DEV, 8'h00, 1);
        do_read(8'h00, 1'b1, 1);
        wbuf[0] = 8'h5A;
        do_write(DEV, 8'h08, 1);
        wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
        do_write(DEV, 8'h06, 3);
        do_read(8'h06, 1'b1, 3);
        do_read(8'h00, 1'b1, 1);
        wbuf[0] = 8'hC3; wbuf[1] = 8'h3C;
        do_write(DEV, 8'hFE, 2);
        do_read(8'hFE, 1'b1, 3);

        wbuf[0] = 8'hEE;
        do_write(7'b1010010, 8'h40, 1);
        do_read(8'h00, 1'b0, 1);

        // Reset while the slave is driving bit 3 of a read byte.
        bus_start;
        send_byte({DEV, 1'b0}, ack);
        send_byte(8'h00, ack);
        ref_ptr = 0;
        bus_start;
        send_byte({DEV, 1'b1}, ack);
        check_eq("rstrd_dev_ack", 16'(ack), 16'h0);
        for (int i = 3; i >= 0; i--) begin
            recv_bit(b);
            nib[i] = b;
        end
        r0 = ref_mem[0];
        check_eq("rstrd_upper_nibble", 16'(nib), 16'(r0[7:4]));
        check_eq("rstrd_bit3_driven", 16'(sda_bus), 16'(r0[3]));
        rst = 1'b1;
        @(negedge clk);
        check_eq("rstrd_sda_released", 16'(sda_bus), 16'h1);
        check_eq("rstrd_busy", 16'(busy), 16'h0);
        rst = 1'b0;
        q_wait;
        bus_stop;
        q_wait;
        ref_ptr = 0;
        txn++;
        $display("txn %0d: read aborted by reset at bit 3", txn);
        do_read(8'h00, 1'b0, 1);

        for (int it = 0; it < 6; it++) begin
            addr = 8'($urandom_range(0, 255));
            n    = int'($urandom_range(1, 4));
            for (int k = 0; k < n; k++) wbuf[k] = 8'($urandom_range(0, 255));
            dev = ($urandom_range(0, 3) == 0) ? 7'b1010100 : DEV;
            do_write(dev, addr, n);
            do_read(addr, 1'b1, int'($urandom_range(1, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/iic_eeprom_slave.md
Name: iic_eeprom_slave

Overview:
Synthesizable I2C responder that models a 24C02-style 256-byte EEPROM. It is the far end of the bus driven by iic_com. It samples SCL/SDA with the system clock and decodes START, STOP and repeated START. It supports byte and page write, current-address read, random read and sequential read against an internal 256x8 array. Used in simulation and on-board loopback to close the loop on the EEPROM write/read test.

Parameters:
DEV_ADDR, 7'b1010000, 7-bit device address matched against the first byte after START.
PAGE_SIZE, 8, page write wrap size in bytes; must be a power of 2 and at most 256.
GLITCH_CYC, 2, number of consecutive equal samples needed before a filtered SCL/SDA level changes.

Ports:
CLK  input  1  system clock, at least 10x the SCL rate.
RST  input  1  synchronous, active-high reset.
SCL  input  1  I2C clock from the master.
SDA  inout  1  I2C data, open-drain: driven 0 or Z, never 1.
Busy  output  1  high from a matched device-address ACK until STOP.
Wr_Pulse  output  1  one-CLK strobe when a data byte is committed to the array.
Wr_Addr  output  8  array address of the last committed byte.
Wr_Data  output  8  value of the last committed byte.

Behaviour:
- Input path:
  - 2-FF synchroniser on SCL and SDA, followed by the GLITCH_CYC filter.
  - Edges are derived from the filtered levels: scl_rise, scl_fall.
  - START: SDA falls while SCL is high. STOP: SDA rises while SCL is high.
- Bus timing:
  - Bits are sampled on scl_rise, MSB first.
  - SDA output changes only on the CLK after scl_fall, so there is a one-cycle hold after the falling edge.
  - sda_oe = 1 drives 0; otherwise SDA is released to Z.
- Reset: state = IDLE, sda_oe = 0, Busy = 0, Wr_Pulse = 0, Wr_Addr = 0, Wr_Data = 0, addr_ptr = 0. Array contents are left unchanged, with no reset loop.
- FSM states and transitions:
  - IDLE: START -> DEVADDR.
  - DEVADDR: shift 8 bits. If [7:1] == DEV_ADDR -> DEVACK; otherwise -> IGNORE with SDA released.
  - DEVACK: drive 0 for one SCL high period, and Busy = 1. Then R/W = 0 -> WORDADDR; R/W = 1 -> RDDATA, with the first byte taken from addr_ptr.
  - WORDADDR: shift 8 bits -> WAACK. At the ACK, addr_ptr <= received byte.
  - WAACK: drive ACK -> WRDATA.
  - WRDATA: shift 8 bits -> WRACK.
    - The byte is written at addr_ptr, with Wr_Pulse, Wr_Addr and Wr_Data updated on the same CLK.
    - addr_ptr[log2(PAGE_SIZE)-1:0] then increments and wraps inside the page; upper bits are unchanged.
  - WRACK: drive ACK -> WRDATA.
  - RDDATA: drive mem[addr_ptr] bit by bit. After the 8th scl_fall, release SDA -> MACK.
  - MACK: sample the master bit on scl_rise.
    - 0 (ACK): addr_ptr <= addr_ptr + 1, wrapping 255 -> 0 across the full array -> RDDATA.
    - 1 (NACK): -> IGNORE.
  - IGNORE: SDA released; wait for STOP or START.
- From any state:
  - STOP -> IDLE, Busy = 0, SDA released.
  - START (repeated) -> DEVADDR, with addr_ptr kept.
  - A random read is therefore a write of the word address followed by a repeated START with R/W = 1.
- Partial byte (STOP/START before 8 bits): discarded, no write, no pointer change.
- Simultaneous START/STOP with an SCL edge: START/STOP takes priority.
- RST asserted mid-transfer: SDA is released within one CLK, the FSM returns to IDLE, and any in-flight byte is dropped.
- No internal write-cycle busy time; the device ACKs immediately after a write.

Test Plan:
- Byte write: dev 0xA0, addr 0x00, data 0x12, STOP. Expect ACK on all 3 bytes, Wr_Pulse once with Wr_Addr = 0x00 and Wr_Data = 0x12, and mem[0] = 0x12.
- Random read: write 0xA0/0x00, repeated START, 0xA1. Expect byte 0x12 on SDA; master NACK then STOP; Busy returns to 0.
- Page wrap: write 0xA0/0x06, then data 0x11, 0x22, 0x33. Expect mem[6] = 0x11, mem[7] = 0x22, mem[0] = 0x33; mem[8] unchanged.
- Sequential read across the top: set ptr 0xFE, read with ACK, ACK, NACK. Expect mem[0xFE], mem[0xFF], mem[0x00].
- Address mismatch: dev 0xA4 -> SDA stays Z for the ACK bit, no write, Busy = 0, and the device recovers on the next START.
- Reset mid-read: assert RST while driving bit 3 of a read byte. SDA is Z on the next CLK, state = IDLE, and the next 0xA1 transaction returns the byte at the retained pointer.
